instr_fetch_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 20 ++
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants, fetch-state encoding and helpers for the instruction fetch stage.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction fetch is word-granular, so redirect targets drop their byte offset.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection (redirect / advance / hold).
module fetch_pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            redirect,
  input  logic            advance,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;

  // Next-PC select: a redirect always wins over sequential advance.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect) begin
      pc_next_s = align_word(redirect_pc);
    end else if (advance) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC state register.
  always_ff @(posedge clock) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipeline IF stage: drives the IMEM word address, captures read data into IF/ID,
// and tracks boot/run/halt, fetch faults, misaligned redirects and a fetch counter.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int              IMEM_AW  = 8,
  parameter int              DEPTH    = 256,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        if_id_pc_o,
  output logic [31:0]        if_id_pc4_o,
  output logic [31:0]        if_id_instr_o,
  output logic               if_id_valid_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic               misalign_o,
  output logic [31:0]        fetch_count_o
);

  localparam logic [XLEN-1:0] PC_LIMIT = 32'(4 * DEPTH);

  fetch_state_e    state_r, state_next_s;
  logic [XLEN-1:0] pc_s;
  logic            redirect_s, advance_s;
  logic            load_instr_s, load_bubble_s;
  logic            set_fault_s, set_misalign_s;
  logic [31:0]     if_id_pc_r, if_id_pc4_r, if_id_instr_r;
  logic            if_id_valid_r, fault_r, misalign_r;
  logic [31:0]     fetch_count_r;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clock       (clock),
    .rst         (rst),
    .redirect    (redirect_s),
    .advance     (advance_s),
    .redirect_pc (redirect_pc_i),
    .pc          (pc_s)
  );

  // Control decode: flush beats stall, stall freezes everything including the FSM.
  always_comb begin
    state_next_s   = state_r;
    redirect_s     = 1'b0;
    advance_s      = 1'b0;
    load_instr_s   = 1'b0;
    load_bubble_s  = 1'b0;
    set_fault_s    = 1'b0;
    set_misalign_s = 1'b0;
    if (flush_i) begin
      redirect_s     = 1'b1;
      load_bubble_s  = 1'b1;
      set_misalign_s = (redirect_pc_i[1:0] != 2'b00);
      state_next_s   = (state_r == BOOT) ? BOOT : RUN;
    end else if (stall_i) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        BOOT: begin
          load_bubble_s = 1'b1;
          state_next_s  = RUN;
        end
        RUN: begin
          if (pc_s < PC_LIMIT) begin
            load_instr_s = 1'b1;
            if (imem_rdata_i == EBREAK_INSTR) begin
              state_next_s = HALT;
            end else begin
              advance_s = 1'b1;
            end
          end else begin
            load_bubble_s = 1'b1;
            set_fault_s   = 1'b1;
            state_next_s  = HALT;
          end
        end
        HALT: begin
          load_bubble_s = 1'b1;
        end
        default: begin
          load_bubble_s = 1'b1;
          state_next_s  = BOOT;
        end
      endcase
    end
  end

  // FSM state, IF/ID register and sticky status flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r       <= BOOT;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_pc4_r   <= 32'h0000_0004;
      if_id_instr_r <= NOP;
      if_id_valid_r <= 1'b0;
      fault_r       <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (load_instr_s) begin
        if_id_pc_r    <= pc_s;
        if_id_pc4_r   <= pc_s + 32'd4;
        if_id_instr_r <= imem_rdata_i;
        if_id_valid_r <= 1'b1;
      end else if (load_bubble_s) begin
        if_id_instr_r <= NOP;
        if_id_valid_r <= 1'b0;
      end else begin
        if_id_instr_r <= if_id_instr_r;
        if_id_valid_r <= if_id_valid_r;
      end
      fault_r    <= fault_r | set_fault_s;
      misalign_r <= misalign_r | set_misalign_s;
    end
  end

  // Saturating count of real instructions latched into IF/ID.
  always_ff @(posedge clock) begin
    if (rst) begin
      fetch_count_r <= 32'h0000_0000;
    end else if (load_instr_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign imem_addr_o   = pc_s[IMEM_AW+1:2];
  assign if_id_pc_o    = if_id_pc_r;
  assign if_id_pc4_o   = if_id_pc4_r;
  assign if_id_instr_o = if_id_instr_r;
  assign if_id_valid_o = if_id_valid_r;
  assign halted_o      = (state_r == HALT);
  assign fault_o       = fault_r;
  assign misalign_o    = misalign_r;
  assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand sequences,
// and randomized traffic compared against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] T_NOP    = 32'h0000_0013;
  localparam logic [31:0] T_EBREAK = 32'h0010_0073;
  localparam logic [31:0] T_LIMIT  = 32'd1024;

  logic        clock = 1'b0;
  logic        rst, stall_i, flush_i;
  logic [31:0] redirect_pc_i;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o, fetch_count_o;
  logic        if_id_valid_o, halted_o, fault_o, misalign_o;

  logic [31:0] imem [0:255];
  assign imem_rdata_i = imem[imem_addr_o];

  always #5 clock = ~clock;

  instr_fetch_unit #(
    .IMEM_AW(8), .DEPTH(256), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)
  ) dut (
    .clock(clock), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .halted_o(halted_o), .fault_o(fault_o),
    .misalign_o(misalign_o), .fetch_count_o(fetch_count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  bit          m_valid, m_fault, m_mis;

  typedef struct {
    bit          s;
    bit          f;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          v;
    bit          h;
    bit          fl;
    bit          m;
    logic [31:0] c;
    logic [7:0]  a;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic add(bit s, bit f, logic [31:0] rd, logic [31:0] pc, logic [31:0] ins, bit v,
                     bit h, bit fl, bit m, logic [31:0] c, logic [7:0] a);
    vec_t t;
    t = '{s, f, rd, pc, ins, v, h, fl, m, c, a};
    tbl.push_back(t);
  endtask

  task automatic model_step(bit r, bit s, bit f, logic [31:0] rd);
    logic [31:0] w;
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_instr = T_NOP;
      m_valid = 1'b0; m_fault = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (f) begin
      m_pc = rd & 32'hFFFF_FFFC;
      m_instr = T_NOP; m_valid = 1'b0;
      if (rd % 4 != 0) m_mis = 1'b1;
      if (m_mode != 0) m_mode = 1;
    end else if (!s) begin
      if (m_mode == 0) begin
        m_instr = T_NOP; m_valid = 1'b0; m_mode = 1;
      end else if (m_mode == 2) begin
        m_instr = T_NOP; m_valid = 1'b0;
      end else if (m_pc < T_LIMIT) begin
        w = imem[m_pc / 4];
        m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = w; m_valid = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (w == T_EBREAK) m_mode = 2;
        else m_pc = m_pc + 4;
      end else begin
        m_instr = T_NOP; m_valid = 1'b0; m_fault = 1'b1; m_mode = 2;
      end
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".addr"},  32'(imem_addr_o), (m_pc / 4) % 256);
    chk({tag, ".pc"},    if_id_pc_o, m_ipc);
    chk({tag, ".pc4"},   if_id_pc4_o, m_ipc4);
    chk({tag, ".instr"}, if_id_instr_o, m_instr);
    chk({tag, ".valid"}, 32'(if_id_valid_o), 32'(m_valid));
    chk({tag, ".halt"},  32'(halted_o), 32'(m_mode == 2));
    chk({tag, ".fault"}, 32'(fault_o), 32'(m_fault));
    chk({tag, ".mis"},   32'(misalign_o), 32'(m_mis));
    chk({tag, ".cnt"},   fetch_count_o, m_cnt);
  endtask

  task automatic step(bit r, bit s, bit f, logic [31:0] rd, string tag);
    rst = r; stall_i = s; flush_i = f; redirect_pc_i = rd;
    model_step(r, s, f, rd);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h100 + i;
    imem[5] = T_EBREAK;

    // s  f  redirect      if_id_pc      instr        v  h  fl m  cnt  addr
    add(0, 0, 32'h0,  32'h0,  T_NOP,        0, 0, 0, 0, 0,  8'h00);
    add(0, 0, 32'h0,  32'h0,  32'h100,      1, 0, 0, 0, 1,  8'h01);
    add(0, 0, 32'h0,  32'h4,  32'h101,      1, 0, 0, 0, 2,  8'h02);
    add(1, 0, 32'h0,  32'h4,  32'h101,      1, 0, 0, 0, 2,  8'h02);
    add(1, 0, 32'h0,  32'h4,  32'h101,      1, 0, 0, 0, 2,  8'h02);
    add(1, 0, 32'h0,  32'h4,  32'h101,      1, 0, 0, 0, 2,  8'h02);
    add(0, 0, 32'h0,  32'h8,  32'h102,      1, 0, 0, 0, 3,  8'h03);
    add(1, 1, 32'h40, 32'h8,  T_NOP,        0, 0, 0, 0, 3,  8'h10);
    add(0, 0, 32'h0,  32'h40, 32'h110,      1, 0, 0, 0, 4,  8'h11);
    add(0, 1, 32'h0,  32'h40, T_NOP,        0, 0, 0, 0, 4,  8'h00);
    add(0, 0, 32'h0,  32'h0,  32'h100,      1, 0, 0, 0, 5,  8'h01);
    add(0, 0, 32'h0,  32'h4,  32'h101,      1, 0, 0, 0, 6,  8'h02);
    add(0, 0, 32'h0,  32'h8,  32'h102,      1, 0, 0, 0, 7,  8'h03);
    add(0, 0, 32'h0,  32'hC,  32'h103,      1, 0, 0, 0, 8,  8'h04);
    add(0, 0, 32'h0,  32'h10, 32'h104,      1, 0, 0, 0, 9,  8'h05);
    add(0, 0, 32'h0,  32'h14, T_EBREAK,     1, 1, 0, 0, 10, 8'h05);
    add(0, 0, 32'h0,  32'h14, T_NOP,        0, 1, 0, 0, 10, 8'h05);
    add(1, 0, 32'h0,  32'h14, T_NOP,        0, 1, 0, 0, 10, 8'h05);
    add(0, 1, 32'h0,  32'h14, T_NOP,        0, 0, 0, 0, 10, 8'h00);
    add(0, 0, 32'h0,  32'h0,  32'h100,      1, 0, 0, 0, 11, 8'h01);
    add(0, 1, 32'h400, 32'h0, T_NOP,        0, 0, 0, 0, 11, 8'h00);
    add(0, 0, 32'h0,  32'h0,  T_NOP,        0, 1, 1, 0, 11, 8'h00);
    add(0, 1, 32'h22, 32'h0,  T_NOP,        0, 0, 1, 1, 11, 8'h08);
    add(0, 0, 32'h0,  32'h20, 32'h108,      1, 0, 1, 1, 12, 8'h09);

    // Reset held for two edges, then the directed table.
    step(1, 0, 0, 32'h0, "rst0");
    step(1, 0, 0, 32'h0, "rst1");
    chk("rst.valid", 32'(if_id_valid_o), 32'h0);
    chk("rst.addr",  32'(imem_addr_o), 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].s, tbl[i].f, tbl[i].rd, $sformatf("mdl%0d", i));
      chk($sformatf("tbl%0d.pc", i),    if_id_pc_o, tbl[i].pc);
      chk($sformatf("tbl%0d.pc4", i),   if_id_pc4_o, tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d.instr", i), if_id_instr_o, tbl[i].ins);
      chk($sformatf("tbl%0d.valid", i), 32'(if_id_valid_o), 32'(tbl[i].v));
      chk($sformatf("tbl%0d.halt", i),  32'(halted_o), 32'(tbl[i].h));
      chk($sformatf("tbl%0d.fault", i), 32'(fault_o), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d.mis", i),   32'(misalign_o), 32'(tbl[i].m));
      chk($sformatf("tbl%0d.cnt", i),   fetch_count_o, tbl[i].c);
      chk($sformatf("tbl%0d.addr", i),  32'(imem_addr_o), 32'(tbl[i].a));
    end

    // Mid-run reset clears sticky flags and everything else in one edge.
    step(1, 0, 0, 32'h0, "midrst");
    chk("midrst.fault", 32'(fault_o), 32'h0);
    chk("midrst.mis",   32'(misalign_o), 32'h0);
    chk("midrst.cnt",   fetch_count_o, 32'h0);
    chk("midrst.instr", if_id_instr_o, T_NOP);
    chk("midrst.pc4",   if_id_pc4_o, 32'h4);

    // Flush during BOOT redirects but keeps the boot bubble cycle.
    step(0, 0, 1, 32'h80, "bootfl");
    chk("bootfl.addr", 32'(imem_addr_o), 32'h20);
    step(0, 0, 0, 32'h0, "bootfl1");
    chk("bootfl1.valid", 32'(if_id_valid_o), 32'h0);
    chk("bootfl1.addr",  32'(imem_addr_o), 32'h20);
    step(0, 0, 0, 32'h0, "bootfl2");
    chk("bootfl2.instr", if_id_instr_o, 32'h120);
    chk("bootfl2.pc",    if_id_pc_o, 32'h80);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++)
      imem[i] = ($urandom_range(0, 15) == 0) ? T_EBREAK : $urandom;
    step(1, 0, 0, 32'h0, "rnd_rst");
    for (int k = 0; k < 3000; k++) begin
      bit          r, s, f;
      logic [31:0] rd;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rd = 32'($urandom_range(0, 1100));
      step(r, s, f, rd, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
